// File: rtl/rx_fifo_param.sv
// Receive FIFO for the SSP path: circular buffer, level-threshold and sticky overrun interrupts.
// Latency: PRDATA_RX valid one cycle after a pop select; flags are combinational from the level register.
// Backpressure: none upstream; a push into a full FIFO with no pop is dropped and flags overrun. Optional RX_TIMEOUT_EN adds the idle timeout.
module rx_fifo_param #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 8,
    parameter int AW             = 3,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              PCLK_RX,
    input  logic              CLEAR_RX,
    input  logic              RX_PUSH,
    input  logic [DATA_W-1:0] RxData,
    input  logic              PSEL_RX,
    input  logic              PWRITE_RX,
    input  logic [AW:0]       RX_THRESH,
    input  logic              RX_ORCLR,
    output logic [DATA_W-1:0] PRDATA_RX,
    output logic [AW:0]       RX_LEVEL,
    output logic              RX_EMPTY,
    output logic              RX_FULL,
    output logic              SSPRXINTR,
    output logic              SSPRORINTR,
    output logic              SSPRTINTR
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              ovr_q, ovr_d;

    logic pop_req;
    logic do_pop;
    logic do_push;
    logic overrun;
    logic fifo_empty;
    logic fifo_full;
    logic [AW:0] thresh_eff;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW+1)'(DEPTH));
    assign pop_req    = PSEL_RX & ~PWRITE_RX;
    assign do_pop     = pop_req & ~fifo_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_push    = RX_PUSH & (~fifo_full | do_pop);
    assign overrun    = RX_PUSH & fifo_full & ~pop_req;
    assign thresh_eff = (RX_THRESH == '0) ? (AW+1)'(1) : RX_THRESH;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        prdata_d = prdata_q;
        ovr_d    = ovr_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop_req) begin
            if (do_pop) begin
                prdata_d = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                prdata_d = '0;
            end
        end

        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        // Set beats clear when both land on the same edge.
        if (RX_ORCLR) begin
            ovr_d = 1'b0;
        end
        if (overrun) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK_RX) begin
        if (CLEAR_RX) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            prdata_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            prdata_q <= prdata_d;
            ovr_q    <= ovr_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge PCLK_RX) begin
        if (do_push && !CLEAR_RX) begin
            mem_q[wr_ptr_q] <= RxData;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (RX_PUSH || pop_req || fifo_empty) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK_RX) begin
        if (CLEAR_RX) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign SSPRTINTR = (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) & ~fifo_empty;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign SSPRTINTR = 1'b0;
`endif

    assign PRDATA_RX  = prdata_q;
    assign RX_LEVEL   = level_q;
    assign RX_EMPTY   = fifo_empty;
    assign RX_FULL    = fifo_full;
    assign SSPRXINTR  = (level_q >= thresh_eff);
    assign SSPRORINTR = ovr_q;

endmodule

// File: tb/tb_rx_fifo_param.sv
// Directed plus randomized bench for rx_fifo_param against a queue-based reference model.
module tb_rx_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TO    = 32;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] din = '0;
    logic          sel = 1'b0;
    logic          wr = 1'b0;
    logic [AW:0]   thr = 4'd1;
    logic          orclr = 1'b0;

    logic [DW-1:0] prdata;
    logic [AW:0]   level;
    logic          empty, full, rxintr, rorintr, rtintr;

    always #5 clk = ~clk;

    rx_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK_RX   (clk),
        .CLEAR_RX  (clr),
        .RX_PUSH   (push),
        .RxData    (din),
        .PSEL_RX   (sel),
        .PWRITE_RX (wr),
        .RX_THRESH (thr),
        .RX_ORCLR  (orclr),
        .PRDATA_RX (prdata),
        .RX_LEVEL  (level),
        .RX_EMPTY  (empty),
        .RX_FULL   (full),
        .SSPRXINTR (rxintr),
        .SSPRORINTR(rorintr),
        .SSPRTINTR (rtintr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word queue, last read value, sticky overrun, idle-cycle count.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_prdata = '0;
    logic          m_ovr = 1'b0;
    int            m_idle = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int thr_eff;
        logic exp_rt;
        thr_eff = (thr == 0) ? 1 : int'(thr);
`ifdef RX_TIMEOUT_EN
        exp_rt = (m_idle == TO) && (mq.size() != 0);
`else
        exp_rt = 1'b0;
`endif
        check({tag, ".prdata"}, 32'(prdata), 32'(m_prdata));
        check({tag, ".level"},  32'(level),  32'(mq.size()));
        check({tag, ".empty"},  32'(empty),  32'(mq.size() == 0));
        check({tag, ".full"},   32'(full),   32'(mq.size() == DEPTH));
        check({tag, ".rxintr"}, 32'(rxintr), 32'(mq.size() >= thr_eff));
        check({tag, ".ror"},    32'(rorintr), 32'(m_ovr));
        check({tag, ".rt"},     32'(rtintr), 32'(exp_rt));
    endtask

    // One clock: drive inputs, advance the model by the behavioural rules, sample #1 after the edge.
    task automatic step(input string tag, input logic p, input logic [DW-1:0] d,
                        input logic s, input logic w, input logic oc, input logic c);
        int  pre_n;
        logic pop;
        clr = c; push = p; din = d; sel = s; wr = w; orclr = oc;
        pop = s & ~w;
        pre_n = mq.size();
        if (c) begin
            mq.delete();
            m_prdata = '0;
            m_ovr = 1'b0;
            m_idle = 0;
        end else begin
            if (p || pop || pre_n == 0) m_idle = 0;
            else if (m_idle < TO) m_idle++;
            if (pop) m_prdata = (pre_n > 0) ? mq.pop_front() : '0;
            if (oc) m_ovr = 1'b0;
            if (p) begin
                if (pre_n < DEPTH || (pop && pre_n > 0)) mq.push_back(d);
                else m_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        clr = 1'b0; push = 1'b0; sel = 1'b0; wr = 1'b0; orclr = 1'b0;
        check_all(tag);
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        step("push", 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_pop();
        step("pop", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_idle();
        step("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        step("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset", 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_level", 32'(level), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);

        // Basic order and 1-cycle read latency
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        check("lvl3", 32'(level), 32'd3);
        do_pop(); check("rd0", 32'(prdata), 32'h11);
        do_pop(); check("rd1", 32'(prdata), 32'h22);
        do_pop(); check("rd2", 32'(prdata), 32'h33);
        check("empty_after", 32'(empty), 32'd1);
        step("pwrite_nop", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_prdata", 32'(prdata), 32'h33);

        // Fill, overrun, drain, clear overrun
        for (int i = 0; i < DEPTH; i++) do_push(8'hA0 + 8'(i));
        check("full", 32'(full), 32'd1);
        do_push(8'hFF);
        check("ovr_set", 32'(rorintr), 32'd1);
        check("ovr_level", 32'(level), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check("drain", 32'(prdata), 32'(8'hA0 + 8'(i)));
        end
        do_pop();
        check("empty_pop_zero", 32'(prdata), 32'd0);
        step("orclr", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_clr", 32'(rorintr), 32'd0);

        // Threshold
        thr = 4'd4;
        do_push(8'h01); do_push(8'h02); do_push(8'h03);
        check("thr_below", 32'(rxintr), 32'd0);
        do_push(8'h04);
        check("thr_at", 32'(rxintr), 32'd1);
        do_pop();
        check("thr_drop", 32'(rxintr), 32'd0);
        while (mq.size() > 0) do_pop();

        // Simultaneous push/pop when full, then when empty
        for (int i = 0; i < DEPTH; i++) do_push(8'hC0 + 8'(i));
        step("full_pp", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_pp_data", 32'(prdata), 32'hC0);
        check("full_pp_lvl", 32'(level), 32'd8);
        check("full_pp_ovr", 32'(rorintr), 32'd0);
        while (mq.size() > 0) do_pop();
        check("last_is_55", 32'(prdata), 32'h55);
        step("empty_pp", 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        check("empty_pp_data", 32'(prdata), 32'd0);
        check("empty_pp_lvl", 32'(level), 32'd1);
        do_pop();
        check("empty_pp_stored", 32'(prdata), 32'h66);

        // Pointer wrap
        for (int i = 0; i < 5; i++) do_push(8'h50 + 8'(i));
        for (int i = 0; i < 5; i++) begin do_pop(); check("wrap5", 32'(prdata), 32'(8'h50 + 8'(i))); end
        for (int i = 0; i < 6; i++) do_push(8'h60 + 8'(i));
        for (int i = 0; i < 6; i++) begin do_pop(); check("wrap6", 32'(prdata), 32'(8'h60 + 8'(i))); end

        // Clear mid-fill
        do_push(8'h71); do_push(8'h72); do_pop(); do_push(8'h73);
        step("clear_mid", 1'b1, 8'h74, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_level", 32'(level), 32'd0);
        check("clr_prdata", 32'(prdata), 32'd0);

        // Timeout
        do_push(8'h81);
        for (int i = 0; i < TO - 1; i++) do_idle();
        check("to_before", 32'(rtintr), 32'd0);
        do_idle();
`ifdef RX_TIMEOUT_EN
        check("to_fire", 32'(rtintr), 32'd1);
`else
        check("to_absent", 32'(rtintr), 32'd0);
`endif
        do_pop();
        check("to_clear", 32'(rtintr), 32'd0);

        // Randomized traffic with shifting push/pop bias
        for (int blk = 0; blk < 8; blk++) begin
            int pp;
            pp = (blk % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 80; i++) begin
                logic p, s, w, oc, c;
                p  = ($urandom_range(99) < pp);
                s  = ($urandom_range(99) < 50);
                w  = ($urandom_range(99) < 20);
                oc = ($urandom_range(99) < 10);
                c  = ($urandom_range(999) < 5);
                if ($urandom_range(99) < 5) thr = 4'($urandom_range(DEPTH));
                step("rand", p, 8'($urandom), s, w, oc, c);
            end
            for (int i = 0; i < 3; i++) do_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rx_fifo_param.md
Name: rx_fifo_param

Overview:
Parametrised receive FIFO for the SSP receive path.
- Buffers words from the serial shifter and returns them on the APB-style read interface.
- Push and pop are independent and may occur in the same cycle.
- Raises a level-threshold receive interrupt and a sticky overrun interrupt. A receive-timeout interrupt is optional.

Parameters:
DATA_W, 8, width of each stored word
DEPTH, 8, number of entries; power of 2, minimum 2
AW, 3, log2(DEPTH); the instantiator sets it consistently with DEPTH
TIMEOUT_CYCLES, 32, idle cycles before the timeout interrupt (used only with RX_TIMEOUT_EN)

Ports:
PCLK_RX  in  1  single clock; all logic is on the rising edge
CLEAR_RX  in  1  reset; synchronous, active-high
RX_PUSH  in  1  shifter strobe; stores RxData this cycle
RxData  in  DATA_W  received word
PSEL_RX  in  1  bus select
PWRITE_RX  in  1  0 = read (pop) when PSEL_RX=1; 1 = no FIFO effect
RX_THRESH  in  AW+1  interrupt threshold, 1..DEPTH; a value of 0 is treated as 1
RX_ORCLR  in  1  pulse that clears the overrun flag
PRDATA_RX  out  DATA_W  registered read data
RX_LEVEL  out  AW+1  current occupancy, 0..DEPTH
RX_EMPTY  out  1  RX_LEVEL==0
RX_FULL  out  1  RX_LEVEL==DEPTH
SSPRXINTR  out  1  RX_LEVEL >= effective threshold
SSPRORINTR  out  1  sticky overrun flag
SSPRTINTR  out  1  timeout interrupt (tied 0 without RX_TIMEOUT_EN)

Behaviour:
- Reset (CLEAR_RX=1 at an edge) has priority over every other input, including an operation in progress:
  - wr_ptr=0, rd_ptr=0, RX_LEVEL=0, PRDATA_RX=0, SSPRORINTR=0, SSPRTINTR=0, timeout counter=0.
  - Memory contents are don't-care.
- Storage: circular buffer with AW-bit pointers that wrap DEPTH-1 -> 0. The level counter is AW+1 bits wide.
- pop = PSEL_RX & ~PWRITE_RX.
- Push:
  - If RX_PUSH=1 and the FIFO is not full (or is full with a pop in the same cycle): mem[wr_ptr] <= RxData and wr_ptr increments.
  - If RX_PUSH=1, the FIFO is full and there is no pop: the word is discarded, pointers and level are unchanged, and SSPRORINTR <= 1.
- Pop:
  - Non-empty: PRDATA_RX <= mem[rd_ptr] at that edge and rd_ptr increments. Data is therefore valid on the cycle after the select (1-cycle latency).
  - Empty: PRDATA_RX <= 0 and nothing else changes. Any push in the same cycle is still stored; there is no bypass.
- Simultaneous push and pop:
  - Non-empty: both take effect and RX_LEVEL is unchanged. This also holds when full, so no overrun is flagged.
  - Empty: the pop returns 0 and the push is stored, so RX_LEVEL becomes 1.
- With no pop, PRDATA_RX holds its last value.
- Level: +1 for a push alone, -1 for a pop alone, unchanged otherwise. It never exceeds DEPTH or drops below 0.
- Flags RX_EMPTY, RX_FULL and SSPRXINTR are combinational from the registered RX_LEVEL and RX_THRESH.
- SSPRORINTR:
  - Cleared by RX_ORCLR.
  - If an overrun and RX_ORCLR occur in the same cycle, the set wins.
- SSPRXINTR deasserts in the cycle after the pop that brings RX_LEVEL below the threshold.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined:
  - A counter resets to 0 on any push, any pop, or whenever the FIFO is empty; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - SSPRTINTR = 1 while the counter == TIMEOUT_CYCLES and the FIFO is non-empty.
  - SSPRTINTR clears on the next push or pop, or on reset.
- Not defined: SSPRTINTR is constant 0 and no counter logic is generated.

Test Plan:
- Reset, then push 0x11,0x22,0x33 and pop 3 times -> PRDATA_RX is 0x11,0x22,0x33, each one cycle after its pop; RX_LEVEL goes 3->0; RX_EMPTY=1.
- Push 8 words 0xA0..0xA7 (DEPTH=8) -> RX_FULL=1; push 0xFF -> SSPRORINTR=1, RX_LEVEL=8; pop all -> 0xA0..0xA7 (0xFF is absent); pulse RX_ORCLR -> SSPRORINTR=0.
- RX_THRESH=4: push 3 -> SSPRXINTR=0; 4th push -> SSPRXINTR=1; one pop -> SSPRXINTR=0 on the next cycle.
- Full FIFO, push 0x55 and pop in the same cycle -> pop returns the oldest word, RX_LEVEL stays 8, SSPRORINTR stays 0. Empty FIFO, push and pop in the same cycle -> PRDATA_RX=0, RX_LEVEL=1.
- Fill 5, pop 5, fill 6, pop 6 (pointer wrap) -> data order preserved; assert CLEAR_RX mid-fill -> all outputs return to reset values on the next cycle.
- With RX_TIMEOUT_EN, TIMEOUT_CYCLES=32: push 1 word and idle -> SSPRTINTR=1 after 32 idle cycles; one pop -> SSPRTINTR=0. Without the macro -> SSPRTINTR stays 0.
